// File: rtl/shot_turn_controller_pkg.sv
// Shared types and constants for the billiard shot/turn sequencing blocks.
// Compiled ahead of the interface and the modules that import billiard_pkg.
package billiard_pkg;

    localparam int AIM_W                  = 5;
    localparam int SPEED_W                = 12;
    localparam int POWER_W                = 6;
    localparam int FIXED_POINT_MULTIPLIER = 64;
    localparam int WHITE_BALL_ID          = 0;

    typedef enum logic [2:0] {
        AIM      = 3'd0,
        CHARGE   = 3'd1,
        FIRE     = 3'd2,
        ROLLING  = 3'd3,
        SETTLE   = 3'd4,
        TURN_END = 3'd5
    } turn_state_t;

endpackage

// File: rtl/shot_turn_controller_if.sv
// Player/table-side signal bundle of shot_turn_controller.
// The slave modport is the controller; the master modport is whoever drives keypad and ball status.
interface shot_turn_controller_if #(
    parameter int NUM_BALLS = 8
);
    import billiard_pkg::*;

    logic                        startOfFrame;
    logic                        shootKey;
    logic signed [AIM_W-1:0]     aimX;
    logic signed [AIM_W-1:0]     aimY;
    logic [NUM_BALLS-1:0]        ballMoving;
    logic [NUM_BALLS-1:0]        pocketed;
    logic                        shotLoad;
    logic signed [SPEED_W-1:0]   shotSpeedX;
    logic signed [SPEED_W-1:0]   shotSpeedY;
    logic [POWER_W-1:0]          power;
    logic                        player;
    logic [2:0]                  turnState;
    logic                        foul;
    logic                        respawnWhite;

    modport slave (
        input  startOfFrame, shootKey, aimX, aimY, ballMoving, pocketed,
        output shotLoad, shotSpeedX, shotSpeedY, power, player, turnState, foul, respawnWhite
    );

    modport master (
        output startOfFrame, shootKey, aimX, aimY, ballMoving, pocketed,
        input  shotLoad, shotSpeedX, shotSpeedY, power, player, turnState, foul, respawnWhite
    );

endinterface

// File: rtl/shot_turn_controller_charger.sv
// shot_power_charger: saturating charge-by-hold power counter and key-release detection.
// Counts only while charge_en is high; clear wins over counting.
module shot_power_charger
    import billiard_pkg::*;
#(
    parameter int MAX_POWER = 63
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_of_frame,
    input  logic               shoot_key,
    input  logic               charge_en,
    input  logic               clear,
    output logic [POWER_W-1:0] power,
    output logic               shot_release
);

    logic [POWER_W-1:0] power_d, power_q;

    always_comb begin
        power_d      = power_q;
        shot_release = 1'b0;
        if (clear) begin
            power_d = '0;
        end else if (charge_en && start_of_frame) begin
            if (shoot_key) begin
                if (power_q < POWER_W'(MAX_POWER)) power_d = power_q + 1'b1;
            end else begin
                shot_release = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) power_q <= '0;
        else       power_q <= power_d;
    end

    assign power = power_q;

endmodule

// File: rtl/shot_turn_controller.sv
// Turn sequencer: aim/charge, one-shot white-ball launch, wait for table to settle, decide next player.
// Optional SHOT_TIMEOUT_EN adds a frame limit on AIM/CHARGE that forfeits the turn as a foul.
module shot_turn_controller
    import billiard_pkg::*;
#(
    parameter int NUM_BALLS     = 8,
    parameter int MAX_POWER     = 63,
    parameter int SETTLE_FRAMES = 4
`ifdef SHOT_TIMEOUT_EN
    ,
    parameter int TIMEOUT_FRAMES = 900
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    shot_turn_controller_if.slave bus
);

    localparam int SETTLE_W = $clog2(SETTLE_FRAMES + 1);

    turn_state_t                state_d, state_q;
    logic                       player_d, player_q;
    logic [NUM_BALLS-1:0]       flags_d, flags_q;
    logic [SETTLE_W-1:0]        settle_d, settle_q;
    logic                       skip_d, skip_q;
    logic                       shot_load_d, shot_load_q;
    logic signed [SPEED_W-1:0]  speed_x_d, speed_x_q;
    logic signed [SPEED_W-1:0]  speed_y_d, speed_y_q;
    logic [NUM_BALLS-1:0]       pocket_now;
    logic                       all_stopped;
    logic                       foul_c, respawn_c, power_clear;
    logic [POWER_W-1:0]         power;
    logic                       shot_release;

`ifdef SHOT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_FRAMES + 1);
    logic [TMO_W-1:0] tmo_cnt_d, tmo_cnt_q;
    logic             timed_out_d, timed_out_q;
`endif

    // -16 has no positive mirror in the aim range; fold it onto -15 so shots stay symmetric.
    function automatic logic signed [AIM_W-1:0] clamp_aim(input logic signed [AIM_W-1:0] a);
        if (a == {1'b1, {(AIM_W-1){1'b0}}}) return {1'b1, {(AIM_W-2){1'b0}}, 1'b1};
        return a;
    endfunction

    function automatic logic signed [SPEED_W-1:0] shot_speed(input logic signed [AIM_W-1:0] a,
                                                             input logic [POWER_W-1:0]      p);
        logic signed [SPEED_W-1:0] prod;
        prod = clamp_aim(a) * $signed({1'b0, p});
        return prod;
    endfunction

    shot_power_charger #(
        .MAX_POWER(MAX_POWER)
    ) u_charger (
        .clk           (clk),
        .reset         (reset),
        .start_of_frame(bus.startOfFrame),
        .shoot_key     (bus.shootKey),
        .charge_en     (state_q == CHARGE),
        .clear         (power_clear),
        .power         (power),
        .shot_release  (shot_release)
    );

    always_comb begin
        state_d     = state_q;
        player_d    = player_q;
        flags_d     = flags_q;
        settle_d    = settle_q;
        skip_d      = skip_q;
        shot_load_d = 1'b0;
        speed_x_d   = speed_x_q;
        speed_y_d   = speed_y_q;
        foul_c      = 1'b0;
        respawn_c   = 1'b0;
        power_clear = 1'b0;
        all_stopped = (bus.ballMoving == '0);
        pocket_now  = flags_q | bus.pocketed;
`ifdef SHOT_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        timed_out_d = timed_out_q;
`endif

        if (state_q != AIM && state_q != CHARGE) flags_d = pocket_now;

        case (state_q)
            AIM: begin
                if (bus.startOfFrame && bus.shootKey && all_stopped) state_d = CHARGE;
            end
            CHARGE: begin
                // Operands are captured on entry so shotLoad and the speeds appear together during FIRE.
                if (shot_release) begin
                    if (power == '0) begin
                        state_d = AIM;
                    end else begin
                        state_d     = FIRE;
                        shot_load_d = 1'b1;
                        speed_x_d   = shot_speed(bus.aimX, power);
                        speed_y_d   = shot_speed(bus.aimY, power);
                    end
                end
            end
            FIRE: begin
                state_d = ROLLING;
                skip_d  = 1'b1;
            end
            ROLLING: begin
                // Motion blocks see the new speed one frame late, so the first frame can read all-stopped.
                if (bus.startOfFrame) begin
                    if (skip_q) begin
                        skip_d = 1'b0;
                    end else if (all_stopped) begin
                        state_d  = SETTLE;
                        settle_d = SETTLE_W'(1);
                    end
                end
            end
            SETTLE: begin
                if (bus.startOfFrame) begin
                    if (!all_stopped) begin
                        state_d  = ROLLING;
                        settle_d = '0;
                    end else begin
                        settle_d = settle_q + 1'b1;
                        if (settle_d == SETTLE_W'(SETTLE_FRAMES)) state_d = TURN_END;
                    end
                end
            end
            TURN_END: begin
                state_d     = AIM;
                flags_d     = '0;
                settle_d    = '0;
                power_clear = 1'b1;
`ifdef SHOT_TIMEOUT_EN
                timed_out_d = 1'b0;
                if (timed_out_q) begin
                    foul_c   = 1'b1;
                    player_d = ~player_q;
                end else
`endif
                if (pocket_now[WHITE_BALL_ID]) begin
                    foul_c    = 1'b1;
                    respawn_c = 1'b1;
                    player_d  = ~player_q;
                end else if (pocket_now == '0) begin
                    player_d = ~player_q;
                end
            end
            default: state_d = AIM;
        endcase

`ifdef SHOT_TIMEOUT_EN
        // Timeout outranks a release on the same frame: the shot is cancelled, not fired.
        if ((state_q == AIM || state_q == CHARGE) && bus.startOfFrame) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            if (tmo_cnt_d == TMO_W'(TIMEOUT_FRAMES)) begin
                state_d     = TURN_END;
                timed_out_d = 1'b1;
                shot_load_d = 1'b0;
                speed_x_d   = speed_x_q;
                speed_y_d   = speed_y_q;
            end
        end
        if (state_d == AIM && state_q != AIM) tmo_cnt_d = '0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= AIM;
            player_q    <= 1'b0;
            flags_q     <= '0;
            settle_q    <= '0;
            skip_q      <= 1'b0;
            shot_load_q <= 1'b0;
            speed_x_q   <= '0;
            speed_y_q   <= '0;
        end else begin
            state_q     <= state_d;
            player_q    <= player_d;
            flags_q     <= flags_d;
            settle_q    <= settle_d;
            skip_q      <= skip_d;
            shot_load_q <= shot_load_d;
            speed_x_q   <= speed_x_d;
            speed_y_q   <= speed_y_d;
        end
    end

`ifdef SHOT_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_q   <= '0;
            timed_out_q <= 1'b0;
        end else begin
            tmo_cnt_q   <= tmo_cnt_d;
            timed_out_q <= timed_out_d;
        end
    end
`endif

    assign bus.shotLoad     = shot_load_q;
    assign bus.shotSpeedX   = speed_x_q;
    assign bus.shotSpeedY   = speed_y_q;
    assign bus.power        = power;
    assign bus.player       = player_q;
    assign bus.turnState    = state_q;
    assign bus.foul         = foul_c;
    assign bus.respawnWhite = respawn_c;

endmodule

// File: tb/tb_shot_turn_controller.sv
// Directed bench for shot_turn_controller: charge/fire, settle, turn passing, reset mid-shot.
// With SHOT_TIMEOUT_EN a second instance with a 5-frame limit exercises the timeout.
module tb_shot_turn_controller;
    import billiard_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    shot_turn_controller_if #(.NUM_BALLS(8)) bus ();

    shot_turn_controller #(
        .NUM_BALLS    (8),
        .MAX_POWER    (63),
        .SETTLE_FRAMES(4)
`ifdef SHOT_TIMEOUT_EN
        ,
        .TIMEOUT_FRAMES(2000)
`endif
    ) dut (
        .clk  (clk),
        .reset(rst),
        .bus  (bus)
    );

`ifdef SHOT_TIMEOUT_EN
    shot_turn_controller_if #(.NUM_BALLS(8)) bus2 ();

    shot_turn_controller #(
        .NUM_BALLS     (8),
        .MAX_POWER     (63),
        .SETTLE_FRAMES (4),
        .TIMEOUT_FRAMES(5)
    ) dut_tmo (
        .clk  (clk),
        .reset(rst),
        .bus  (bus2)
    );
`endif

    // Event monitor: counts one-clk pulses and remembers the speeds seen with shotLoad.
    int n_load = 0, n_foul = 0, n_resp = 0, n_tend = 0;
    int ld_x = 0, ld_y = 0;
    always @(negedge clk) begin
        if (bus.shotLoad) begin
            n_load++;
            ld_x = int'(bus.shotSpeedX);
            ld_y = int'(bus.shotSpeedY);
        end
        if (bus.foul)               n_foul++;
        if (bus.respawnWhite)       n_resp++;
        if (bus.turnState == 3'd5)  n_tend++;
    end

    task automatic check_val(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // One frame: startOfFrame for one clk, then two quiet clks.
    task automatic frame(input logic key, input logic [7:0] mv);
        bus.shootKey     = key;
        bus.ballMoving   = mv;
        bus.startOfFrame = 1'b1;
        @(negedge clk);
        bus.startOfFrame = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic frames(input int n, input logic key, input logic [7:0] mv);
        for (int i = 0; i < n; i++) frame(key, mv);
    endtask

    task automatic pocket_pulse(input logic [7:0] p);
        bus.pocketed = p;
        @(negedge clk);
        bus.pocketed = '0;
        @(negedge clk);
    endtask

`ifdef SHOT_TIMEOUT_EN
    task automatic frame2();
        bus2.startOfFrame = 1'b1;
        @(negedge clk);
        bus2.startOfFrame = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int l0, f0, r0, t0;
        rst = 1'b1;
        bus.startOfFrame = 1'b0;
        bus.shootKey     = 1'b0;
        bus.aimX         = '0;
        bus.aimY         = '0;
        bus.ballMoving   = '0;
        bus.pocketed     = '0;
`ifdef SHOT_TIMEOUT_EN
        bus2.startOfFrame = 1'b0;
        bus2.shootKey     = 1'b0;
        bus2.aimX         = '0;
        bus2.aimY         = '0;
        bus2.ballMoving   = '0;
        bus2.pocketed     = '0;
`endif
        repeat (3) @(negedge clk);
        check_val("reset_state",    int'(bus.turnState), 0);
        check_val("reset_power",    int'(bus.power), 0);
        check_val("reset_player",   int'(bus.player), 0);
        check_val("reset_shotload", int'(bus.shotLoad), 0);
        check_val("reset_speedx",   int'(bus.shotSpeedX), 0);
        check_val("reset_foul",     int'(bus.foul), 0);
        rst = 1'b0;
        @(negedge clk);

        // Shot 1: enter CHARGE, then 10 charging frames, release with aim (3,-2).
        bus.aimX = 5'sd3;
        bus.aimY = -5'sd2;
        frame(1'b1, 8'h00);
        check_val("t1_state_charge", int'(bus.turnState), 1);
        check_val("t1_power_entry",  int'(bus.power), 0);
        frames(10, 1'b1, 8'h00);
        check_val("t1_power10", int'(bus.power), 10);
        l0 = n_load;
        frame(1'b0, 8'h00);
        check_val("t1_load_count", n_load - l0, 1);
        check_val("t1_speedx", ld_x, 30);
        check_val("t1_speedy", ld_y, -20);
        check_val("t1_state_rolling", int'(bus.turnState), 3);
        check_val("t1_speedx_held", int'(bus.shotSpeedX), 30);

        // Balls 0 and 2 roll for 5 frames, then 4 still frames end the turn.
        f0 = n_foul; t0 = n_tend;
        frames(5, 1'b0, 8'h05);
        check_val("t3_still_rolling", int'(bus.turnState), 3);
        frames(3, 1'b0, 8'h00);
        check_val("t3_settle", int'(bus.turnState), 4);
        frame(1'b0, 8'h00);
        check_val("t3_turn_end_seen", n_tend - t0, 1);
        check_val("t3_state_aim", int'(bus.turnState), 0);
        check_val("t3_player", int'(bus.player), 1);
        check_val("t3_no_foul", n_foul - f0, 0);
        check_val("t3_power_cleared", int'(bus.power), 0);

        // Shot 2: 100 held frames saturate at 63; aimY -16 clamps to -15.
        bus.aimX = 5'sd15;
        bus.aimY = 5'b10000;
        frame(1'b1, 8'h00);
        frames(100, 1'b1, 8'h00);
        check_val("t2_power_sat", int'(bus.power), 63);
        l0 = n_load;
        frame(1'b0, 8'h00);
        check_val("t2_load_count", n_load - l0, 1);
        check_val("t2_speedx", ld_x, 945);
        check_val("t2_speedy", ld_y, -945);

        // Object ball 2 pocketed: player keeps the turn.
        f0 = n_foul;
        pocket_pulse(8'h04);
        frames(5, 1'b0, 8'h00);
        check_val("t4_obj_state", int'(bus.turnState), 0);
        check_val("t4_obj_player", int'(bus.player), 1);
        check_val("t4_obj_no_foul", n_foul - f0, 0);

        // White pocketed: foul, respawn, turn passes.
        bus.aimX = 5'sd1;
        bus.aimY = 5'sd1;
        frame(1'b1, 8'h00);
        frames(2, 1'b1, 8'h00);
        frame(1'b0, 8'h00);
        check_val("t4_white_speedx", ld_x, 2);
        f0 = n_foul; r0 = n_resp;
        pocket_pulse(8'h01);
        frames(5, 1'b0, 8'h00);
        check_val("t4_white_foul", n_foul - f0, 1);
        check_val("t4_white_respawn", n_resp - r0, 1);
        check_val("t4_white_player", int'(bus.player), 0);

        // Shoot key ignored while a ball still moves; zero-power release aborts to AIM.
        frame(1'b1, 8'h01);
        check_val("aim_ignore_moving", int'(bus.turnState), 0);
        l0 = n_load;
        frame(1'b1, 8'h00);
        frame(1'b0, 8'h00);
        check_val("zero_power_abort_state", int'(bus.turnState), 0);
        check_val("zero_power_no_load", n_load - l0, 0);

        // Zero aim shot, then settle interrupted at count 3.
        bus.aimX = '0;
        bus.aimY = '0;
        frame(1'b1, 8'h00);
        frame(1'b1, 8'h00);
        frame(1'b0, 8'h00);
        check_val("zero_aim_load", n_load - l0, 1);
        check_val("zero_aim_speedx", ld_x, 0);
        check_val("zero_aim_speedy", ld_y, 0);
        t0 = n_tend;
        frames(4, 1'b0, 8'h00);
        check_val("t5_settle3", int'(bus.turnState), 4);
        frame(1'b0, 8'h04);
        check_val("t5_back_rolling", int'(bus.turnState), 3);
        frames(3, 1'b0, 8'h00);
        check_val("t5_still_settle", int'(bus.turnState), 4);
        check_val("t5_no_early_end", n_tend - t0, 0);
        frame(1'b0, 8'h00);
        check_val("t5_turn_end", n_tend - t0, 1);
        check_val("t5_player", int'(bus.player), 1);

        // Reset in CHARGE with power 20.
        frame(1'b1, 8'h00);
        frames(20, 1'b1, 8'h00);
        check_val("t6_power20", int'(bus.power), 20);
        l0 = n_load;
        rst = 1'b1;
        @(negedge clk);
        check_val("t6_rst_power", int'(bus.power), 0);
        check_val("t6_rst_state", int'(bus.turnState), 0);
        check_val("t6_rst_player", int'(bus.player), 0);
        bus.shootKey = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        frames(2, 1'b0, 8'h00);
        check_val("t6_no_load", n_load - l0, 0);
        check_val("t6_state_after", int'(bus.turnState), 0);

`ifdef SHOT_TIMEOUT_EN
        // Timeout instance: idle in AIM for 5 frames forfeits the turn.
        repeat (4) begin
            frame2();
            @(negedge clk);
        end
        check_val("tmo_before", int'(bus2.turnState), 0);
        frame2();
        check_val("tmo_state_end", int'(bus2.turnState), 5);
        check_val("tmo_foul", int'(bus2.foul), 1);
        check_val("tmo_respawn", int'(bus2.respawnWhite), 0);
        @(negedge clk);
        check_val("tmo_player", int'(bus2.player), 1);
        check_val("tmo_state_aim", int'(bus2.turnState), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shot_turn_controller.md
Name: shot_turn_controller

Overview:
Sequences each shot in the billiard game. Per turn it:
- accepts aim and a charge-by-hold power from the player,
- loads a one-shot initial velocity into the hit (white) ball motion block,
- waits until every ball on the table has stopped,
- decides whether the turn passes to the other player.

It sits between the keypad/aim logic and the per-ball motion/collision blocks, and its state feeds the score/HUD drawing.

Parameters:
- NUM_BALLS, 8, number of balls; index 0 is the white (hit) ball.
- MAX_POWER, 63, saturation value of the power counter (≤63, fits 6 bits).
- SETTLE_FRAMES, 4, consecutive all-stopped frames required to end ROLLING.
- TIMEOUT_FRAMES, 900, frames allowed in AIM (only with SHOT_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- startOfFrame  in  1  one-clk pulse per frame.
- shootKey  in  1  level; high while the shot key is held.
- aimX  in  5 signed  aim direction X, valid range -15..15.
- aimY  in  5 signed  aim direction Y, valid range -15..15.
- ballMoving  in  NUM_BALLS  bit i high while ball i has nonzero speed.
- pocketed  in  NUM_BALLS  one-clk pulse when ball i drops into a pocket.
- shotLoad  out  1  one-clk pulse; the white ball loads shotSpeedX/Y as its speed.
- shotSpeedX  out  12 signed  initial X speed, in 1/64 pixel per frame.
- shotSpeedY  out  12 signed  initial Y speed, in 1/64 pixel per frame.
- power  out  6  current charge, for the HUD bar.
- player  out  1  player whose turn it is (0/1).
- turnState  out  3  state encoding, for debug and HUD.
- foul  out  1  one-clk pulse at turn end if the white ball was pocketed.
- respawnWhite  out  1  one-clk pulse together with foul.

Behaviour:
Reset values:
- All outputs 0; state AIM; player 0.
- Power counter, settle counter and pocket flags cleared.
- Reset is honoured mid-shot: any state returns to AIM immediately, and shotLoad is never emitted during or after reset.

States (3-bit encoding): AIM=0, CHARGE=1, FIRE=2, ROLLING=3, SETTLE=4, TURN_END=5.

AIM:
- power=0.
- shootKey high on a startOfFrame cycle -> CHARGE.
- shootKey is ignored unless ballMoving==0.

CHARGE:
- On each startOfFrame with shootKey high, power+1, saturating at MAX_POWER.
- On a startOfFrame with shootKey low: power==0 -> AIM; otherwise -> FIRE.

FIRE (exactly one clk):
- Operands are latched on this clk.
- aimX/aimY of -16 are clamped to -15.
- shotSpeedX = aimX*power and shotSpeedY = aimY*power; both are signed products with |value| ≤ 945.
- shotLoad=1 on this clk; shotSpeedX/Y hold their values until the next FIRE.
- aimX=aimY=0 is legal: the shot produces zero speed.
- Next state: ROLLING.

ROLLING:
- The pocket flags are OR'd with pocketed on every clk from FIRE through TURN_END.
- On startOfFrame, if ballMoving==0 -> SETTLE and the settle counter is set to 1.
- The first startOfFrame after FIRE is skipped (motion blocks need one frame to register speed).

SETTLE:
- On each startOfFrame: ballMoving==0 increments the settle counter; any moving ball returns to ROLLING and clears the counter.
- When the counter reaches SETTLE_FRAMES -> TURN_END.

TURN_END (one clk):
- White pocketed (flag bit 0): foul=1, respawnWhite=1, player toggles.
- Otherwise, any object ball pocketed: player unchanged.
- Otherwise: player toggles.
- Flags and power are cleared; next state AIM.

Simultaneous events:
- A pocketed pulse in the same clk as a state transition is still captured.
- startOfFrame and the FIRE clk never coincide, because FIRE is entered on a startOfFrame and lasts one clk.

Optional Feature:
Macro SHOT_TIMEOUT_EN.
- Defined: a frame counter runs in AIM and CHARGE and clears on entry to AIM. Reaching TIMEOUT_FRAMES forces TURN_END with no shot, player toggles, and foul=1 with respawnWhite=0.
- Undefined: no counter; AIM and CHARGE wait indefinitely.

Decomposition:
- Package billiard_pkg holds:
  - the turn_state_t enum (3-bit, values as above);
  - AIM_W=5, SPEED_W=12, POWER_W=6, FIXED_POINT_MULTIPLIER=64;
  - the WHITE_BALL_ID=0 constant.
- One sub-module, shot_power_charger: owns the saturating power counter and the release detection, with outputs power and release. The FSM, pocket flags and settle counter stay in the top module.

Test Plan:
1. Reset, then hold shootKey for 10 frames and release with aimX=3, aimY=-2 -> one shotLoad pulse with shotSpeedX=30, shotSpeedY=-20; state goes to ROLLING.
2. Hold shootKey for 100 frames with aimX=15, aimY=-16 -> power saturates at 63; shotSpeedX=945, shotSpeedY=-945.
3. After a shot, ballMoving=0x05 for 5 frames, then 0 for 4 frames, with no pocketed pulses -> TURN_END after the 4th still frame; player 0->1; foul=0.
4. During ROLLING, pocketed=0x04 for one clk -> turn ends with player unchanged and no foul. Then pocketed bit 0 on the next turn -> foul=1, respawnWhite=1, player toggles.
5. SETTLE with the counter at 3, then ballMoving bit 2 rises -> back to ROLLING and counter cleared; a further 4 still frames are required.
6. Assert reset in CHARGE with power=20 -> power=0, state AIM, no shotLoad. With SHOT_TIMEOUT_EN and TIMEOUT_FRAMES=5, idle in AIM for 5 frames -> foul=1, respawnWhite=0, player toggles.
